// File: rtl/uart_frame_check.sv
// UART RX frame checker: assembles LSB-first data bits from the sampler,
// checks optional parity and one or two stop bits, and counts bad frames.
module uart_frame_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              sampled_bit,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_two_stop,
  input  logic              clr_count,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              stop_error,
  output logic [CNT_W-1:0]  err_count
);

  // state  | meaning
  // IDLE   | waiting for frame_start
  // DATA   | collecting DATA_W data bits
  // PARITY | waiting for the parity bit
  // STOP1  | waiting for the first stop bit
  // STOP2  | waiting for the second stop bit
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP1  = 3'd3;
  localparam logic [2:0] S_STOP2  = 3'd4;

  localparam int              BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              two_stop_q, two_stop_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              par_err_q, par_err_d;
  logic              stop_err_q, stop_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              done;

  // Frame sequencing; frame_start always restarts, even mid-frame.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    two_stop_d   = two_stop_q;
    busy_d       = busy_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;
    done         = 1'b0;
    if (frame_start) begin
      state_d    = S_DATA;
      bit_cnt_d  = '0;
      shift_d    = '0;
      par_en_d   = cfg_par_en;
      par_odd_d  = cfg_par_odd;
      two_stop_d = cfg_two_stop;
      par_err_d  = 1'b0;
      stop_err_d = 1'b0;
      busy_d     = 1'b1;
    end else if (bit_valid) begin
      case (state_q)
        S_DATA: begin
          // shift register is cleared at frame start, so OR-ing in the bit is enough
          shift_d   = shift_q | (DATA_W'(sampled_bit) << bit_cnt_q);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP1;
        end
        S_PARITY: begin
          par_err_d = (sampled_bit != ((^shift_q) ^ par_odd_q));
          state_d   = S_STOP1;
        end
        S_STOP1: begin
          if (!sampled_bit) stop_err_d = 1'b1;
          if (two_stop_q) state_d = S_STOP2;
          else            done    = 1'b1;
        end
        S_STOP2: begin
          if (!sampled_bit) stop_err_d = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
    if (done) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      data_out_d   = shift_q;
      data_valid_d = 1'b1;
    end
  end

  // Error counter acts on the flags seen during the data_valid cycle; clear wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_count)
      err_cnt_d = '0;
    else if (data_valid_q && (par_err_q || stop_err_q) && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      two_stop_q   <= two_stop_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign busy         = busy_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = par_err_q;
  assign stop_error   = stop_err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_uart_frame_check;
  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start, bit_valid, sampled_bit;
  logic       cfg_par_en, cfg_par_odd, cfg_two_stop, clr_count;
  logic       busy, data_valid, parity_error, stop_error;
  logic [7:0] data_out, err_count;
  logic       busy_s, data_valid_s, parity_error_s, stop_error_s;
  logic [7:0] data_out_s;
  logic [1:0] err_count_s;

  int checks = 0;
  int fails  = 0;
  int dv_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_check #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
    .cfg_two_stop(cfg_two_stop), .clr_count(clr_count), .busy(busy),
    .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
    .stop_error(stop_error), .err_count(err_count));

  uart_frame_check #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
    .cfg_two_stop(cfg_two_stop), .clr_count(clr_count), .busy(busy_s),
    .data_out(data_out_s), .data_valid(data_valid_s), .parity_error(parity_error_s),
    .stop_error(stop_error_s), .err_count(err_count_s));

  always @(posedge clk) if (data_valid) dv_cnt <= dv_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic pe, input logic po, input logic ts, input logic bv_too, input logic bv_val);
    @(negedge clk);
    frame_start = 1'b1; cfg_par_en = pe; cfg_par_odd = po; cfg_two_stop = ts;
    bit_valid = bv_too; sampled_bit = bv_val;
    @(negedge clk);
    frame_start = 1'b0; bit_valid = 1'b0;
    // mid-frame config changes must be ignored
    cfg_par_en = ~pe; cfg_par_odd = ~po; cfg_two_stop = ~ts;
    check_eq("busy_after_start", busy, 1'b1);
  endtask

  task automatic strobe(input logic b);
    @(negedge clk);
    bit_valid = 1'b1; sampled_bit = b;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic po,
                           input logic ts, input logic pbit, input logic s1, input logic s2,
                           input logic exp_pe, input logic exp_se, input logic clr_at_dv,
                           input logic bv_at_start);
    start(pe, po, ts, bv_at_start, 1'b0);
    for (int i = 0; i < 8; i++) strobe(d[i]);
    if (pe) strobe(pbit);
    strobe(s1);
    if (ts) begin
      check_eq({tag, "_no_dv_after_stop1"}, data_valid, 1'b0);
      strobe(s2);
    end
    check_eq({tag, "_dv"}, data_valid, 1'b1);
    check_eq({tag, "_busy_low"}, busy, 1'b0);
    check_eq({tag, "_data"}, data_out, d);
    check_eq({tag, "_perr"}, parity_error, exp_pe);
    check_eq({tag, "_serr"}, stop_error, exp_se);
    if (clr_at_dv) clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    check_eq({tag, "_dv_one_cycle"}, data_valid, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int dv_before;
    rst = 1'b1; frame_start = 0; bit_valid = 0; sampled_bit = 0;
    cfg_par_en = 0; cfg_par_odd = 0; cfg_two_stop = 0; clr_count = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_dv", data_valid, 0);
    check_eq("rst_flags", {parity_error, stop_error}, 0);
    check_eq("rst_cnt", err_count, 0);
    rst = 1'b0;

    run_frame("a5", 8'hA5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    check_eq("a5_cnt", err_count, 0);

    // 0x07 has three ones: even parity bit must be 1
    run_frame("par_bad", 8'h07, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    check_eq("par_bad_cnt", err_count, 1);
    run_frame("par_ok", 8'h07, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    check_eq("par_ok_cnt", err_count, 1);
    run_frame("par_odd_ok", 8'h07, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    check_eq("par_odd_cnt", err_count, 1);

    run_frame("st01", 8'h3C, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    check_eq("st01_cnt", err_count, 2);
    run_frame("st10", 8'h3C, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    check_eq("st10_cnt", err_count, 3);
    run_frame("st11", 8'h3C, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    check_eq("st11_cnt", err_count, 3);

    // abort after 4 bits; restart coincides with a bit_valid that must be dropped
    dv_before = dv_cnt;
    start(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) strobe(1'b0);
    run_frame("abort", 8'h55, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    check_eq("abort_dv_count", dv_cnt - dv_before, 1);
    check_eq("abort_cnt", err_count, 3);

    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
    check_eq("clr_cnt", err_count, 0);
    check_eq("clr_cnt_sat", err_count_s, 0);

    for (int k = 1; k <= 5; k++) begin
      run_frame("sat", 8'hFF, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      check_eq("sat_cnt2", err_count_s, (k > 3) ? 3 : k);
      check_eq("sat_cnt8", err_count, k);
    end
    run_frame("clr_win", 8'h81, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    check_eq("clr_win_cnt2", err_count_s, 0);
    check_eq("clr_win_cnt8", err_count, 0);
    run_frame("pre_rst", 8'h96, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    check_eq("pre_rst_cnt", err_count, 1);

    // async reset mid-DATA
    start(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_data", data_out, 0);
    check_eq("arst_flags", {parity_error, stop_error, data_valid}, 0);
    check_eq("arst_cnt", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    dv_before = dv_cnt;
    for (int i = 0; i < 12; i++) strobe(1'b1);
    repeat (2) @(negedge clk);
    check_eq("stray_no_dv", dv_cnt - dv_before, 0);
    check_eq("stray_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
